bus_timer: RTL

Memory-mapped countdown timer that responds to the MEM-stage bus: the bridge decodes the CPU's load/store address (AO) and forwards word offset, store data (V2) and write strobe here. It exposes three 32-bit registers, counts down from a software preset, and raises an interrupt request toward CP0. Two modes are supported: one-shot and auto-reload.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bus_timer.sv | 103 ++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL bit positions and mode codes.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CNT  = 2'd1,
        INT  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/bus_timer.sv
// Countdown timer on the MEM-stage bus: CTRL/PRESET/COUNT registers, a
// one-shot or auto-reload countdown FSM, and an interrupt request to CP0.
module bus_timer
    import timer_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    state_t      state, state_n;
    logic [3:0]  ctrl, ctrl_n;
    logic [31:0] preset, preset_n;
    logic [31:0] count, count_n;
    logic        pending, pending_n;

    logic wr_ctrl, wr_preset, en, reload;

    // Bus handshake: WE is a one-cycle strobe with no ready; a write with WE=1
    // is accepted at the rising edge it is sampled, reads are combinational.
    assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
    assign wr_preset = WE && (Addr == ADDR_PRESET);
    assign en        = ctrl[CTRL_EN];
    assign reload    = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            ctrl    <= ctrl_n;
            preset  <= preset_n;
            count   <= count_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        state_n   = state;
        ctrl_n    = ctrl;
        preset_n  = preset;
        count_n   = count;
        pending_n = (wr_ctrl || wr_preset) ? 1'b0 : pending;

        if (wr_preset) preset_n = DIN;

        case (state)
            IDLE: begin
                if (en) begin
                    count_n = preset;
                    state_n = CNT;
                end
            end
            CNT: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (count <= 32'd1) begin
                    // Covers PRESET=0 too: expire instead of wrapping below zero.
                    count_n   = '0;
                    pending_n = 1'b1;
                    state_n   = INT;
                    if (!reload) ctrl_n[CTRL_EN] = 1'b0;
                end else begin
                    count_n = count - 32'd1;
                end
            end
            INT: begin
                if (reload) begin
                    pending_n = 1'b0;
                    count_n   = preset;
                    state_n   = CNT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Software CTRL write overrides the hardware Enable clear on the same edge.
        if (wr_ctrl) ctrl_n = DIN[3:0];
    end

    always_comb begin
        DOUT = '0;
        case (Addr)
            ADDR_CTRL:   DOUT = {28'd0, ctrl};
            ADDR_PRESET: DOUT = preset;
            ADDR_COUNT:  DOUT = count;
            default:     DOUT = '0;
        endcase
    end

    assign IRQ = pending & ctrl[CTRL_IM];

endmodule
